// File: rtl/norm_unit_pkg.sv
// Shared definitions for the normalize unit.
//   - state_e : control FSM states (2-bit encoding)
//   - OP_CLZ / OP_CTZ : operation select values carried on i_op
//   - DATA_W / CNT_W : datapath and count widths
package norm_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CTZ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/norm_unit_bit_rev32.sv
// Purely combinational 32-bit bit reversal: o_data[i] = i_data[31-i].
// Ports:
//   i_data  input  32  operand
//   o_data  output 32  operand with bit order reversed
module bit_rev32 (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  for (genvar i = 0; i < 32; i++) begin : g_rev
    assign o_data[i] = i_data[31-i];
  end

endmodule

// File: rtl/norm_unit.sv
// Iterative CLZ/CTZ normalize unit.
// A request is latched in IDLE; five RUN cycles then perform a binary search
// for the leading one (stages of 16/8/4/2/1 bits), and the result is held in
// DONE until the consumer takes it. CTZ reuses the CLZ datapath by loading the
// operand bit-reversed and reversing the shifted work register on output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds i_valid/i_data/i_op until accepted; the unit
// holds o_valid and the result stable until i_ready is seen.
//
// Ports:
//   i_clk        input   1  clock, rising edge
//   i_rst        input   1  synchronous active-high reset
//   i_valid      input   1  request valid
//   o_ready      output  1  unit idle, can accept
//   i_data       input  32  operand
//   i_op         input   1  0 = CLZ, 1 = CTZ
//   o_valid      output  1  result valid (DONE)
//   i_ready      input   1  consumer accepts result
//   o_count      output  6  zero count 0..32
//   o_norm       output 32  normalized operand
//   o_zero       output  1  operand was zero
//   o_dbg_state  output  2  current FSM state (debug visibility)
module norm_unit
  import norm_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_norm,
  output logic              o_zero,
  output logic [1:0]        o_dbg_state
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        stage_q, stage_d;
  logic              op_q, op_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] data_rev;
  logic [DATA_W-1:0] work_rev;
  logic              upper_zero;
  logic [DATA_W-1:0] work_shifted;

  bit_rev32 u_rev_in (
    .i_data (i_data),
    .o_data (data_rev)
  );

  bit_rev32 u_rev_out (
    .i_data (work_q),
    .o_data (work_rev)
  );

  // One binary-search step: test the top 2^k bits and the matching fixed shift.
  always_comb begin
    upper_zero   = 1'b0;
    work_shifted = work_q;
    case (stage_q)
      3'd4: begin
        upper_zero   = (work_q[31:16] == 16'd0);
        work_shifted = {work_q[15:0], 16'd0};
      end
      3'd3: begin
        upper_zero   = (work_q[31:24] == 8'd0);
        work_shifted = {work_q[23:0], 8'd0};
      end
      3'd2: begin
        upper_zero   = (work_q[31:28] == 4'd0);
        work_shifted = {work_q[27:0], 4'd0};
      end
      3'd1: begin
        upper_zero   = (work_q[31:30] == 2'd0);
        work_shifted = {work_q[29:0], 2'd0};
      end
      3'd0: begin
        upper_zero   = ~work_q[31];
        work_shifted = {work_q[30:0], 1'b0};
      end
      default: begin
        upper_zero   = 1'b0;
        work_shifted = work_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    op_d    = op_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = RUN;
          work_d  = (i_op == OP_CTZ) ? data_rev : i_data;
          op_d    = i_op;
          zero_d  = (i_data == '0);
          cnt_d   = 5'd0;
          stage_d = 3'd4;
        end
      end
      RUN: begin
        if (upper_zero) begin
          work_d = work_shifted;
          cnt_d  = cnt_q | (5'd1 << stage_q);
        end
        if (stage_q == 3'd0) begin
          state_d = DONE;
        end else begin
          stage_d = stage_q - 3'd1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      op_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  // Result outputs are forced to zero outside DONE so stale work state never leaks.
  always_comb begin
    o_ready     = (state_q == IDLE);
    o_valid     = (state_q == DONE);
    o_dbg_state = state_q;
    o_count     = '0;
    o_norm      = '0;
    o_zero      = 1'b0;
    if (state_q == DONE) begin
      o_zero = zero_q;
      if (zero_q) begin
        o_count = CNT_W'(DATA_W);
        o_norm  = '0;
      end else begin
        o_count = {1'b0, cnt_q};
        o_norm  = (op_q == OP_CTZ) ? work_rev : work_q;
      end
    end
  end

endmodule

// File: tb/tb_norm_unit.sv
// Directed bench for norm_unit with a result scoreboard.
module tb_norm_unit;
  import norm_unit_pkg::*;

  localparam int RES_W = 39;  // {zero, count[5:0], norm[31:0]}

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_op;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_count;
  logic [31:0] o_norm;
  logic        o_zero;
  logic [1:0]  o_dbg_state;

  logic [RES_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  norm_unit dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_op        (i_op),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_norm      (o_norm),
    .o_zero      (o_zero),
    .o_dbg_state (o_dbg_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Reference: scan bits directly, independent of the staged search.
  function automatic logic [RES_W-1:0] model(input logic [31:0] d, input logic op);
    int n;
    logic [31:0] nv;
    n = 0;
    if (d == 32'd0) return {1'b1, 6'd32, 32'd0};
    if (op == OP_CLZ) begin
      while (d[31-n] == 1'b0) n++;
      nv = d << n;
    end else begin
      while (d[n] == 1'b0) n++;
      nv = d >> n;
    end
    return {1'b0, 6'(n), nv};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] outs();
    return {o_zero, o_count, o_norm};
  endfunction

  // Driver: wait for ready (bounded), present one request for one edge.
  task automatic send(input logic [31:0] d, input logic op);
    int w;
    w = 0;
    while (!o_ready && w < 50) begin
      @(posedge i_clk); #1;
      w++;
    end
    check("send_ready", 40'(o_ready), 40'd1);
    i_valid = 1'b1;
    i_data  = d;
    i_op    = op;
    exp_q.push_back(model(d, op));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Monitor: called right after acceptance; checks latency, result, hold, handshake.
  task automatic recv(input int hold, input bit toggle);
    int cyc;
    logic [RES_W-1:0] e;
    cyc = 0;
    check("exp_q_nonempty", 40'(exp_q.size() != 0), 40'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    while (!o_valid && cyc < 20) begin
      check("busy_outs_zero", 40'(outs()), 40'd0);
      if (toggle) begin
        i_valid = 1'b1;
        i_data  = $urandom;
        i_op    = 1'($urandom_range(0, 1));
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check("latency", 40'(cyc), 40'd5);
    check("result", 40'(outs()), 40'(e));
    check("done_ready", 40'(o_ready), 40'd0);
    for (int h = 0; h < hold; h++) begin
      i_ready = 1'b0;
      @(posedge i_clk); #1;
      check("hold_result", 40'(outs()), 40'(e));
      check("hold_valid", 40'(o_valid), 40'd1);
      check("hold_ready", 40'(o_ready), 40'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("post_hs_ready", 40'(o_ready), 40'd1);
    check("post_hs_valid", 40'(o_valid), 40'd0);
    check("post_hs_outs", 40'(outs()), 40'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        op;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 32'd0;
    i_op    = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", 40'(o_ready), 40'd1);
    check("rst_valid", 40'(o_valid), 40'd0);
    check("rst_outs", 40'(outs()), 40'd0);
    check("rst_state", 40'(o_dbg_state), 40'(IDLE));
    i_rst = 1'b0;

    send(32'h0001_0000, OP_CLZ); recv(0, 1'b0);
    send(32'h0000_0100, OP_CTZ); recv(0, 1'b0);
    send(32'h0000_0000, OP_CLZ); recv(0, 1'b0);
    send(32'h0000_0000, OP_CTZ); recv(1, 1'b0);
    send(32'h8000_0000, OP_CLZ); recv(3, 1'b0);
    send(32'h8000_0000, OP_CTZ); recv(0, 1'b0);
    send(32'h0000_0001, OP_CTZ); recv(0, 1'b0);
    send(32'hFFFF_FFFF, OP_CLZ); recv(0, 1'b0);

    // Abort in the third RUN cycle; the request must never be presented.
    send(32'h0000_0F00, OP_CLZ);
    void'(exp_q.pop_back());
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("abort_valid", 40'(o_valid), 40'd0);
    check("abort_ready", 40'(o_ready), 40'd1);
    check("abort_outs", 40'(outs()), 40'd0);
    repeat (6) begin
      @(posedge i_clk); #1;
      check("abort_no_result", 40'(o_valid), 40'd0);
    end
    send(32'h0000_0001, OP_CLZ); recv(0, 1'b0);

    // Inputs churn (with i_valid high) during RUN; result must not change.
    send(32'h00FF_0000, OP_CLZ); recv(0, 1'b1);

    for (int k = 0; k < 10; k++) begin
      d  = $urandom >> $urandom_range(0, 31);
      d  = d << $urandom_range(0, 31);
      op = 1'($urandom_range(0, 1));
      send(d, op);
      recv($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/norm_unit.md
NORM_UNIT -- requirements
Module: norm_unit

Interface
REQ-001 Parameters SHALL be none; datapath width SHALL be fixed at 32 bits.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous and active-high.
REQ-004 i_valid  input  1  request valid from the producer.
REQ-005 o_ready  output  1  unit can accept a request; SHALL equal 1 only in state IDLE.
REQ-006 i_data  input  32  operand to normalize.
REQ-007 i_op  input  1  operation: 0 = CLZ (count leading zeros), 1 = CTZ (count trailing zeros).
REQ-008 o_valid  output  1  result valid; SHALL equal 1 only in state DONE.
REQ-009 i_ready  input  1  consumer accepts the result.
REQ-010 o_count  output  6  zero count, range 0..32.
REQ-011 o_norm  output  32  normalized operand.
- CLZ: i_data << o_count.
- CTZ: i_data >> o_count (logical).
REQ-012 o_zero  output  1  operand was all zeros.

Function
REQ-013 A request SHALL be accepted on a rising edge where i_valid = 1 and o_ready = 1.
- On acceptance, latch the work register, i_op and a zero flag (i_data == 0).
- For CTZ, the work register SHALL be loaded with i_data bit-reversed.
- The count SHALL be cleared and the stage index set to 4.
REQ-014 State machine IDLE -> RUN -> DONE -> IDLE; the state encoding SHALL be 2 bits.
- IDLE->RUN on acceptance.
- RUN->DONE on the edge that processes stage 0.
- DONE->IDLE on the edge where i_ready = 1.
REQ-015 In RUN, stage k (processed 4,3,2,1,0, one stage per cycle) SHALL test the upper 2^k bits of the work register.
- If they are all zero: shift the work register left by 2^k with zero fill, and set count bit k.
- Otherwise: leave the work register and count bit k unchanged.
REQ-016 Latency SHALL be exactly 5 cycles: acceptance on edge E, stages on edges E+1..E+5, o_valid = 1 from edge E+5.
REQ-017 In DONE:
- o_count = 32 if the zero flag is set, otherwise the accumulated count.
- o_norm = work register for CLZ, or bit-reversed work register for CTZ.
- o_norm = 0 when the zero flag is set.
- o_zero = zero flag.
REQ-018 o_count, o_norm and o_zero SHALL hold stable while o_valid = 1 and i_ready = 0 (indefinite backpressure allowed).
REQ-019 After a result handshake, o_ready SHALL be 1 on the following cycle; there SHALL be no acceptance in the handshake cycle itself.
REQ-020 i_data and i_op SHALL be ignored except at acceptance; changes during RUN or DONE SHALL NOT affect the result.
REQ-021 i_valid while o_ready = 0 SHALL be ignored; the producer holds the request until accepted.
REQ-022 o_count, o_norm and o_zero SHALL be 0 whenever o_valid = 0.

Reset
REQ-023 When i_rst = 1 on an edge, the unit SHALL enter IDLE with work register, count, stage index, op and zero flag all cleared.
- o_valid = 0, o_ready = 1 and all result outputs = 0 from that edge.
REQ-024 Reset in RUN or DONE SHALL abort the operation; the in-flight request and result SHALL be discarded and never presented.
REQ-025 i_rst SHALL take priority over acceptance and result handshake on the same edge.

Structure
REQ-026 A shared package SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the op constants OP_CLZ = 1'b0 and OP_CTZ = 1'b1;
- the width constant 32.
REQ-027 The bit reversal SHALL be one combinational sub-module, bit_rev32, instantiated for the operand load and for the result output.
REQ-028 No multiplier or full barrel shifter SHALL be used; each stage uses a fixed shift selected by the stage index.

Verification
REQ-029 CLZ, i_data = 0x0001_0000 -> o_valid 5 cycles after acceptance, o_count = 15, o_norm = 0x8000_0000, o_zero = 0.
REQ-030 CTZ, i_data = 0x0000_0100 -> o_count = 8, o_norm = 0x0000_0001, o_zero = 0.
REQ-031 CLZ and CTZ with i_data = 0 -> o_count = 32, o_norm = 0, o_zero = 1.
REQ-032 CLZ, i_data = 0x8000_0000 -> o_count = 0, o_norm = 0x8000_0000; then hold i_ready = 0 for 3 cycles -> outputs stable, o_ready = 0; o_ready = 1 the cycle after the handshake.
REQ-033 Assert i_rst in the 3rd RUN cycle -> next cycle o_valid = 0, o_ready = 1, outputs 0; a new CLZ request of 0x0000_0001 -> o_count = 31.
REQ-034 Toggle i_data and i_op every cycle during RUN after accepting CLZ 0x00FF_0000 -> result unaffected: o_count = 8, o_norm = 0xFF00_0000.
